ysyx_25060166_mem_arbiter: RTL
==============================

// Module: ysyx_25060166_mem_arbiter
// PURPOSE
//   Shares the CPU's single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
//   Each requester uses a valid/ready request handshake and receives a one-cycle response pulse.
//   The arbiter holds one outstanding transaction, sequences it onto the memory port and routes the response back.
//   A watchdog converts a stalled memory port into an error response. Sits between IFU/LSU and the RAM.
// PARAMETERS
//   WIDTH     32   data/address width (matches `ysyx_25060166_WIDTH)
//   TIMEOUT   255  cycles allowed from entering REQ until response, before error; >=2
// PORTS
//   clk             in   1      clock, all state on posedge
//   rst             in   1      reset, asynchronous, active-low (0 = in reset)
//   ifu_req_valid   in   1      IFU fetch request
//   ifu_req_ready   out  1      IFU request accepted this cycle
//   ifu_addr        in   WIDTH  fetch address
//   ifu_rsp_valid   out  1      one-cycle response pulse to IFU
//   ifu_rdata       out  WIDTH  fetched instruction
//   ifu_rsp_err     out  1      response is a timeout error
//   lsu_req_valid   in   1      LSU load/store request
//   lsu_req_ready   out  1      LSU request accepted this cycle
//   lsu_addr        in   WIDTH  data address
//   lsu_wen         in   1      1 = store, 0 = load
//   lsu_wdata       in   WIDTH  store data
//   lsu_wmask       in   4      byte enables for store
//   lsu_rsp_valid   out  1      one-cycle response pulse to LSU
//   lsu_rdata       out  WIDTH  load data
//   lsu_rsp_err     out  1      response is a timeout error
//   mem_req_valid   out  1      request to memory
//   mem_req_ready   in   1      memory accepts request
//   mem_addr        out  WIDTH  registered address
//   mem_wen         out  1      registered write enable
//   mem_wdata       out  WIDTH  registered write data
//   mem_wmask       out  4      registered byte mask
//   mem_rsp_valid   in   1      memory response (rdata valid)
//   mem_rdata       in   WIDTH  memory read data
// BEHAVIOUR
//   - Reset (rst=0, async): state IDLE, owner=IFU, last_grant=IFU, watchdog=0. All outputs 0, incl. *_req_ready.
//   - FSM IDLE -> REQ -> RSP -> IDLE.
//   - IDLE grant:
//     - Only one valid: that master wins.
//     - Both valid: the master not in last_grant wins (alternating round-robin); after reset, LSU wins first.
//     - Winner's req_ready is combinational (state==IDLE & winner & rst=1). Loser's req_ready stays 0.
//     - On handshake: latch addr/wen/wdata/wmask into mem_* regs. IFU owner forces wen=0, wmask=0.
//     - Update owner and last_grant, clear watchdog, go to REQ.
//   - REQ: mem_req_valid=1; mem_* fields stay stable until mem_req_ready=1, then go to RSP.
//   - RSP: mem_req_valid=0. On mem_rsp_valid: register mem_rdata into owner's rdata; owner rsp_valid=1 for exactly one cycle, err=0; go to IDLE.
//   - Latency: accept at cycle N; mem_req_valid from N+1; memory ready at N+1 and response at N+2 give owner rsp_valid at N+3.
//   - Watchdog:
//     - Counts every cycle in REQ and RSP; saturates at TIMEOUT; cleared in IDLE.
//     - On reaching TIMEOUT without mem_rsp_valid in RSP: owner rsp_valid=1 and err=1, rdata=0, mem_req_valid=0, go to IDLE.
//     - Timeout and mem_rsp_valid in the same cycle: the response wins, err=0.
//   - mem_rsp_valid outside RSP is ignored.
//   - Non-owner rsp_valid is never asserted. rdata holds its last value between responses.
//   - Masters issue no new request before their response; no request is accepted while state != IDLE.
//   - rst=0 mid-transaction: aborts immediately; no response is delivered after reset release.
// TESTING
//   - IFU read @0x80000000, mem ready at once, rsp 0x00000413 next cycle -> ifu_rsp_valid 1 pulse with 0x00000413, mem_wen=0, lsu_rsp_valid=0.
//   - Both valid after reset; LSU store 0x80001000/0xDEADBEEF/4'b0011 -> LSU granted first, mem_wmask=4'b0011; IFU next; a further contention grants LSU.
//   - mem_req_ready low 3 cycles -> mem_req_valid and mem_addr stable 4 cycles; no second req_ready pulse.
//   - TIMEOUT=8, memory silent -> owner rsp_valid with err=1, rdata=0; a late mem_rsp_valid in IDLE produces no pulse.
//   - Drive rst=0 while in RSP -> all outputs 0 immediately; after release, no rsp_valid until a new request completes.

Source files
------------

// File: rtl/ysyx_25060166_mem_arbiter_if.sv
// Bus bundle between the IFU, LSU, RAM port and the memory arbiter.
// The arbiter takes the slave view; the surrounding CPU/RAM (or a bench) takes the master view.
interface ysyx_25060166_mem_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             ifu_req_valid;
  logic             ifu_req_ready;
  logic [WIDTH-1:0] ifu_addr;
  logic             ifu_rsp_valid;
  logic [WIDTH-1:0] ifu_rdata;
  logic             ifu_rsp_err;

  logic             lsu_req_valid;
  logic             lsu_req_ready;
  logic [WIDTH-1:0] lsu_addr;
  logic             lsu_wen;
  logic [WIDTH-1:0] lsu_wdata;
  logic [3:0]       lsu_wmask;
  logic             lsu_rsp_valid;
  logic [WIDTH-1:0] lsu_rdata;
  logic             lsu_rsp_err;

  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_wen;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0]       mem_wmask;
  logic             mem_rsp_valid;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_25060166_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one transaction in flight,
// with a watchdog that turns a silent memory into an error response.
module ysyx_25060166_mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input logic                          clk,
  input logic                          rst,
  ysyx_25060166_mem_arbiter_if.slave   bus
);

  localparam int              WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  state_t state, state_next;
  owner_t owner, last_grant;

  logic [WD_W-1:0]  wdog;
  logic             grant_ifu, grant_lsu;
  logic             accept;
  logic             mem_req_valid_c;
  logic             rsp_ok, rsp_timeout, done;

  logic [WIDTH-1:0] mem_addr_q, mem_wdata_q;
  logic             mem_wen_q;
  logic [3:0]       mem_wmask_q;

  logic             ifu_rsp_valid_q, ifu_rsp_err_q;
  logic [WIDTH-1:0] ifu_rdata_q;
  logic             lsu_rsp_valid_q, lsu_rsp_err_q;
  logic [WIDTH-1:0] lsu_rdata_q;

  // Under contention the master that did not win last time gets the port.
  assign grant_lsu = bus.lsu_req_valid & (~bus.ifu_req_valid | (last_grant == OWN_IFU));
  assign grant_ifu = bus.ifu_req_valid & ~grant_lsu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    accept          = 1'b0;
    mem_req_valid_c = 1'b0;
    rsp_ok          = 1'b0;
    rsp_timeout     = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_ifu | grant_lsu) begin
          accept     = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        mem_req_valid_c = 1'b1;
        if (bus.mem_req_ready) begin
          state_next = RSP;
        end
      end
      RSP: begin
        // A response arriving on the last allowed cycle still beats the watchdog.
        if (bus.mem_rsp_valid) begin
          rsp_ok     = 1'b1;
          state_next = IDLE;
        end else if (wdog == WD_MAX) begin
          rsp_timeout = 1'b1;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign done = rsp_ok | rsp_timeout;

  // Ready is gated by rst so nothing is acknowledged while the block is held in reset.
  assign bus.ifu_req_ready = accept & grant_ifu & rst;
  assign bus.lsu_req_ready = accept & grant_lsu & rst;
  assign bus.mem_req_valid = mem_req_valid_c;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wmask     = mem_wmask_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner       <= OWN_IFU;
      last_grant  <= OWN_IFU;
      wdog        <= '0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      if (accept) begin
        owner       <= grant_lsu ? OWN_LSU : OWN_IFU;
        last_grant  <= grant_lsu ? OWN_LSU : OWN_IFU;
        mem_addr_q  <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
        mem_wen_q   <= grant_lsu & bus.lsu_wen;
        mem_wdata_q <= grant_lsu ? bus.lsu_wdata : '0;
        mem_wmask_q <= grant_lsu ? bus.lsu_wmask : 4'b0000;
      end
      if (state == IDLE) begin
        wdog <= '0;
      end else if (wdog != WD_MAX) begin
        wdog <= wdog + WD_W'(1);
      end
    end
  end

  // Response pulses last one cycle; rdata holds until the same master's next response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifu_rsp_valid_q <= 1'b0;
      ifu_rsp_err_q   <= 1'b0;
      ifu_rdata_q     <= '0;
      lsu_rsp_valid_q <= 1'b0;
      lsu_rsp_err_q   <= 1'b0;
      lsu_rdata_q     <= '0;
    end else begin
      ifu_rsp_valid_q <= done & (owner == OWN_IFU);
      ifu_rsp_err_q   <= rsp_timeout & (owner == OWN_IFU);
      lsu_rsp_valid_q <= done & (owner == OWN_LSU);
      lsu_rsp_err_q   <= rsp_timeout & (owner == OWN_LSU);
      if (done && owner == OWN_IFU) begin
        ifu_rdata_q <= rsp_ok ? bus.mem_rdata : '0;
      end
      if (done && owner == OWN_LSU) begin
        lsu_rdata_q <= rsp_ok ? bus.mem_rdata : '0;
      end
    end
  end

  assign bus.ifu_rsp_valid = ifu_rsp_valid_q;
  assign bus.ifu_rsp_err   = ifu_rsp_err_q;
  assign bus.ifu_rdata     = ifu_rdata_q;
  assign bus.lsu_rsp_valid = lsu_rsp_valid_q;
  assign bus.lsu_rsp_err   = lsu_rsp_err_q;
  assign bus.lsu_rdata     = lsu_rdata_q;

endmodule
